word_deserializer_1to8: RTL and testbench

Stream deserializer that collects up to 8 consecutive WIDTH-bit words from a valid/ready input stream and presents them as one 8-lane parallel bundle. It is the inverse of the 8-to-1 lane selection used on the serializing side. It sits between a narrow producer, such as a bus read port or FIFO, and wide consumers that need a whole group at once, such as a line fill or vector register load. A group closes after the 8th word or early on an input last marker.

---
 rtl/word_deserializer_1to8_pkg.sv | 10 +
 rtl/word_deserializer_1to8.sv | 71 +++++++
 tb/tb_word_deserializer_1to8.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/word_deserializer_1to8_pkg.sv
// rtl/word_deserializer_1to8_pkg.sv - shared constants and types for the 1-to-8 word deserializer
package word_deserializer_1to8_pkg;

    localparam int LANES      = 8;
    localparam int LANE_IDX_W = 3;
    localparam int COUNT_W    = 4;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/word_deserializer_1to8.sv
// rtl/word_deserializer_1to8.sv - collects up to 8 stream words into one parallel lane bundle
module word_deserializer_1to8
    import word_deserializer_1to8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_valid,
    input  logic                   i_last,
    output logic                   o_ready,
    output logic [LANES*WIDTH-1:0] o_data,
    output logic [COUNT_W-1:0]     o_count,
    output logic                   o_valid,
    input  logic                   i_ready
);

    lane_idx_t                idx_q;
    logic [LANES*WIDTH-1:0]   asm_q;
    logic [LANES*WIDTH-1:0]   group_d;
    logic                     in_beat;
    logic                     out_beat;
    logic                     complete;

    always_comb begin
        o_ready  = !o_valid || i_ready;
        in_beat  = i_valid && o_ready;
        out_beat = o_valid && i_ready;
        complete = in_beat && ((idx_q == lane_idx_t'(LANES - 1)) || i_last);
    end

    // Closing group: lanes below idx come from assembly, lane idx is the live word, the rest are zero.
    always_comb begin
        group_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_idx_t'(k) < idx_q) begin
                group_d[k*WIDTH +: WIDTH] = asm_q[k*WIDTH +: WIDTH];
            end else if (lane_idx_t'(k) == idx_q) begin
                group_d[k*WIDTH +: WIDTH] = i_data;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            idx_q   <= '0;
            asm_q   <= '0;
            o_data  <= '0;
            o_count <= '0;
            o_valid <= 1'b0;
        end else begin
            if (out_beat) begin
                o_valid <= 1'b0;
                o_count <= '0;
            end
            // A completing beat overrides the drain above so back-to-back groups have no bubble.
            if (complete) begin
                o_data  <= group_d;
                o_count <= {1'b0, idx_q} + COUNT_W'(1);
                o_valid <= 1'b1;
                idx_q   <= '0;
                asm_q   <= '0;
            end else if (in_beat) begin
                asm_q[idx_q*WIDTH +: WIDTH] <= i_data;
                idx_q                       <= idx_q + lane_idx_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_deserializer_1to8.sv
// tb/tb_word_deserializer_1to8.sv - scoreboard bench for word_deserializer_1to8
module tb_word_deserializer_1to8;

    localparam int W = 32;
    localparam int L = 8;

    logic             i_clock = 1'b0;
    logic             i_reset = 1'b0;
    logic [W-1:0]     i_data  = '0;
    logic             i_valid = 1'b0;
    logic             i_last  = 1'b0;
    logic             i_ready = 1'b0;
    logic             o_ready;
    logic [L*W-1:0]   o_data;
    logic [3:0]       o_count;
    logic             o_valid;

    word_deserializer_1to8 #(.WIDTH(W)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_count (o_count),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 i_clock = ~i_clock;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]   part[$];
    logic [L*W-1:0] exp_data[$];
    int             exp_cnt[$];
    logic           mvalid  = 1'b0;
    logic           in_reset = 1'b1;

    function automatic void chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Reference: words accumulate in a list; a group closes at 8 words or on last.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r,
                         output logic beat);
        logic           nxt;
        logic [L*W-1:0] g;
        @(negedge i_clock);
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_ready = r;
        #1;
        chk("o_ready", o_ready, !mvalid || r);
        chk("o_valid", o_valid, mvalid);
        if (!mvalid) chk("idle_count", o_count, 0);
        beat = v && (!mvalid || r);
        nxt  = (mvalid && r) ? 1'b0 : mvalid;
        if (beat) begin
            part.push_back(d);
            if (l || part.size() == L) begin
                g = '0;
                foreach (part[k]) g[k*W +: W] = part[k];
                exp_data.push_back(g);
                exp_cnt.push_back(part.size());
                part.delete();
                nxt = 1'b1;
            end
        end
        mvalid = nxt;
    endtask

    task automatic do_reset(input int n);
        @(negedge i_clock);
        i_reset  = 1'b0;
        i_valid  = 1'b1;
        i_data   = $urandom;
        i_last   = 1'b0;
        i_ready  = 1'b0;
        in_reset = 1'b1;
        part.delete();
        exp_data.delete();
        exp_cnt.delete();
        mvalid = 1'b0;
        repeat (n) @(posedge i_clock);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ready", o_ready, 1);
        i_reset  = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: every output beat must match the oldest expected group.
    initial begin
        forever begin
            @(negedge i_clock);
            #2;
            if (!in_reset && o_valid === 1'b1 && i_ready === 1'b1) begin
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_group: got count %0d data %0h expected none", o_count, o_data);
                end else begin
                    chk("group_data", o_data, exp_data.pop_front());
                    chk("group_count", o_count, exp_cnt.pop_front());
                end
            end
        end
    end

    initial begin
        logic b;
        int   acc;
        int   n;
        do_reset(2);

        for (int i = 0; i < 8; i++) cycle(1'b1, W'((i + 1) * 'h11), 1'b0, 1'b1, b);
        for (int i = 0; i < 8; i++) cycle(1'b1, W'('h91 + i), 1'b0, 1'b1, b);
        repeat (2) cycle(1'b0, 'x, 1'b0, 1'b1, b);

        cycle(1'b1, 'hA, 1'b0, 1'b1, b);
        cycle(1'b1, 'hB, 1'b0, 1'b1, b);
        cycle(1'b1, 'hC, 1'b1, 1'b1, b);
        cycle(1'b1, 'hD, 1'b1, 1'b1, b);
        repeat (2) cycle(1'b0, 'x, 1'b0, 1'b1, b);

        for (int i = 0; i < 8; i++) cycle(1'b1, W'('h101 + i), 1'b0, 1'b1, b);
        repeat (5) cycle(1'b1, 'h201, 1'b0, 1'b0, b);
        for (int i = 0; i < 8; i++) cycle(1'b1, W'('h201 + i), 1'b0, 1'b1, b);
        repeat (2) cycle(1'b0, 'x, 1'b0, 1'b1, b);

        for (int i = 0; i < 4; i++) cycle(1'b1, W'('h301 + i), 1'b0, 1'b1, b);
        do_reset(1);
        for (int i = 0; i < 8; i++) cycle(1'b1, W'(i + 1), 1'b0, 1'b1, b);
        repeat (2) cycle(1'b0, 'x, 1'b0, 1'b1, b);

        for (int i = 0; i < 8; i++) cycle(1'b1, W'('h401 + i), i == 7, 1'b1, b);
        repeat (2) cycle(1'b0, 'x, 1'b0, 1'b1, b);

        acc = 0;
        n   = 0;
        while (acc < 1000 && n < 20000) begin
            cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) < 7), b);
            if (b) acc++;
            n++;
        end
        chk("random_words_accepted", acc, 1000);
        cycle(1'b1, 'h5A5A, 1'b1, 1'b1, b);
        repeat (4) cycle(1'b0, 'x, 1'b0, 1'b1, b);
        chk("queue_empty", exp_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
